scan_unload_ctrl: RTL and testbench
===================================

// Module: scan_unload_ctrl
// PURPOSE
//  Controller that sits directly on a scan chain built from ScanReg/ScanReg8/32/40 cells; drives their sen/ce/sin, consumes sout.
//  On request: optionally captures functional d into the chain, then serially unloads CHAIN_LEN bits.
//  Packs the bits LSB-first into WORD_W-bit words and hands them downstream on a valid/ready port.
//  Recirculate mode feeds sout back to sin, so the chain contents are intact after a full unload.
// PARAMETERS
//  CHAIN_LEN  40  total scan bits in the attached chain (>=1)
//  WORD_W     32  output word width (>=1)
// PORTS
//  clk         in   1        single clock; all state updates on posedge
//  clr_n       in   1        synchronous reset, active low
//  start       in   1        request an unload; sampled only in IDLE
//  cap         in   1        sampled with start: 1 = one capture cycle before shifting
//  recirc      in   1        sampled with start: 1 = chain_sin=chain_sout, 0 = chain_sin=0
//  func_ce     in   1        functional clock-enable, passed to chain_ce while idle
//  chain_sen   out  1        to chain sen
//  chain_ce    out  1        to chain ce
//  chain_sin   out  1        to chain sin (first cell)
//  chain_sout  in   1        from chain sout (last cell, q[0])
//  out_data    out  WORD_W   packed scan word
//  out_valid   out  1        out_data valid
//  out_ready   in   1        downstream accepts when out_valid&&out_ready at posedge
//  busy        out  1        high in every state except IDLE
//  done        out  1        one-cycle pulse when the unload completes
// BEHAVIOUR
//  - Reset (clr_n=0 at posedge): state=IDLE, bit/word counters=0, out_valid=0, out_data=0, done=0.
//    While clr_n=0: chain_ce=0, chain_sen=0. A reset mid-unload abandons it; the chain keeps its partial-shift contents.
//  - States: IDLE -> (start) CAPTURE if cap else SHIFT; CAPTURE -> SHIFT after 1 cycle;
//    SHIFT -> DRAIN after the last bit is taken; DRAIN -> DONE once out_valid=0 (or is cleared that cycle);
//    DONE -> IDLE after 1 cycle.
//  - IDLE: chain_sen=0, chain_ce=func_ce, chain_sin=0, busy=0. start is ignored when busy=1.
//  - CAPTURE: chain_sen=0, chain_ce=1 (load d); func_ce ignored.
//  - SHIFT: chain_sen=1, chain_ce=1 unless stalled. Each unstalled cycle samples chain_sout before the edge.
//    It writes that bit to acc[bit_idx] and increments the bit counter.
//  - Packing: first bit out -> bit 0 of word 0. NW = ceil(CHAIN_LEN/WORD_W) words. The final word is zero-padded above bit (CHAIN_LEN-1)%WORD_W.
//    CHAIN_LEN=40, WORD_W=32 gives 2 words; word1 carries valid data in [7:0] only.
//  - Word completion: on the cycle that shifts the last bit of a word, out_data <= {assembled word}, out_valid <= 1, acc cleared.
//    This cycle is allowed only if the output slot is free (out_valid=0 or out_ready=1).
//    Otherwise it is a stall: chain_ce=0, no sample, counters hold.
//  - out_valid drops on acceptance unless a new word loads on the same edge. out_data is stable while out_valid && !out_ready.
//  - Minimum latency start->done: (cap?1:0) + CHAIN_LEN + 1 (DRAIN) + 1 cycles, with out_ready held 1.
//  - done: high only in DONE; busy=1 in CAPTURE/SHIFT/DRAIN/DONE.
//  - recirc/cap are latched at start; changes during busy have no effect. chain_sin is combinational from chain_sout when recirc is latched.
// STRUCTURE
//  - scan_defs.vh: state encodings (IDLE, CAPTURE, SHIFT, DRAIN, DONE) as localparams, clog2 helper macro.
//  - Sub-module scan_word_pack: bit accumulator + word counter + output register with the valid/ready slot.
//    It exports slot_free and last_bit_of_word; the FSM and chain muxing stay in scan_unload_ctrl.
// TESTING  (DUT wired to a ScanReg40 chain, CHAIN_LEN=40, WORD_W=32)
//  1 Preload chain 40'h12_3456_789A via d + func_ce, start cap=0 recirc=0, out_ready=1 ->
//    words 32'h3456789A then 32'h00000012; done at cycle 42; chain reads 0.
//  2 Same with recirc=1 -> same words; chain q = 40'h12_3456_789A afterwards.
//  3 cap=1 with d=40'hFF_0000_0001 -> capture cycle (sen=0,ce=1) first; words 32'h00000001, 32'h000000FF.
//  4 out_ready=0 for 10 cycles after word0 valid -> chain_ce=0 exactly on the stalled last-bit-of-word1 cycle;
//    out_data held; final words unchanged; done delayed by the stall.
//  5 clr_n=0 at bit 20 of SHIFT -> next cycle IDLE, out_valid=0, busy=0; a new start then unloads normally.
//  6 start pulsed while busy, and func_ce toggled during SHIFT -> ignored; idle chain_ce follows func_ce after done.

Source files
------------

// File: rtl/scan_unload_ctrl_pkg.sv
// Package: scan_unload_ctrl_pkg
// Shared controller state encoding plus small elaboration-time helpers
// used to size the packing counters.
package scan_unload_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Bits needed to index n items. The result is never below 1, so
    // counters stay legal for degenerate sizes.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) w++;
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int unsigned num_words(input int unsigned bits,
                                              input int unsigned width);
        return (bits + width - 1) / width;
    endfunction

endpackage

// File: rtl/scan_unload_ctrl_word_pack.sv
// Module: scan_unload_ctrl_word_pack
// Collects serial scan bits LSB-first into WORD_W-bit words and presents
// each completed word on a single-entry valid/ready output slot.
// Ports:
//   clk, clr_n          clock, synchronous active-low reset
//   shift_i             take bit_i this cycle (caller guarantees slot room)
//   bit_i               serial bit from the chain
//   out_ready_i         downstream ready
//   out_data_o/valid_o  output slot
//   slot_free_o         slot empty or being emptied this cycle
//   last_bit_of_word_o  next bit taken completes a word
//   last_bit_o          next bit taken is the final bit of the chain
module scan_unload_ctrl_word_pack
    import scan_unload_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 40,
    parameter int unsigned WORD_W    = 32
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              shift_i,
    input  logic              bit_i,
    input  logic              out_ready_i,
    output logic [WORD_W-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              slot_free_o,
    output logic              last_bit_of_word_o,
    output logic              last_bit_o
);

    localparam int unsigned NW        = num_words(CHAIN_LEN, WORD_W);
    localparam int unsigned BW        = clog2_min1(WORD_W);
    localparam int unsigned WCW       = clog2_min1(NW);
    localparam int unsigned LAST_BITS = ((CHAIN_LEN - 1) % WORD_W) + 1;

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [WORD_W-1:0] word_c;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WCW-1:0]    word_q, word_d;
    logic              valid_q, valid_d;

    assign last_bit_o         = (word_q == WCW'(NW - 1)) && (bit_q == BW'(LAST_BITS - 1));
    assign last_bit_of_word_o = (bit_q == BW'(WORD_W - 1)) || last_bit_o;
    assign slot_free_o        = !valid_q || out_ready_i;
    assign out_data_o         = data_q;
    assign out_valid_o        = valid_q;

    always_comb begin
        word_c        = acc_q;
        word_c[bit_q] = bit_i;

        acc_d   = acc_q;
        bit_d   = bit_q;
        word_d  = word_q;
        data_d  = data_q;
        valid_d = valid_q;

        if (valid_q && out_ready_i) valid_d = 1'b0;

        if (shift_i) begin
            if (last_bit_of_word_o) begin
                // Bits above the last written index were cleared with acc,
                // which zero-pads a short final word.
                data_d  = word_c;
                valid_d = 1'b1;
                acc_d   = '0;
                bit_d   = '0;
                word_d  = last_bit_o ? '0 : word_q + 1'b1;
            end else begin
                acc_d = word_c;
                bit_d = bit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            acc_q   <= '0;
            data_q  <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            data_q  <= data_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/scan_unload_ctrl.sv
// Module: scan_unload_ctrl
// Drives a scan chain's sen/ce/sin to optionally capture functional data
// and then serially unload CHAIN_LEN bits, packed LSB-first into WORD_W-bit
// words on a valid/ready port. Recirculate mode feeds sout back into sin so
// the chain is intact after a full unload.
// Ports:
//   clk, clr_n                 clock, synchronous active-low reset
//   start, cap, recirc         unload request and its options (IDLE only)
//   func_ce                    functional clock-enable passed through in IDLE
//   chain_sen/ce/sin           chain controls; chain_sout chain serial output
//   out_data/out_valid/out_ready  packed word output
//   busy                       not idle; done one-cycle completion pulse
module scan_unload_ctrl
    import scan_unload_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 40,
    parameter int unsigned WORD_W    = 32
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              cap,
    input  logic              recirc,
    input  logic              func_ce,
    output logic              chain_sen,
    output logic              chain_ce,
    output logic              chain_sin,
    input  logic              chain_sout,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    state_e state_q, state_d;
    logic   recirc_q, recirc_d;
    logic   sen_c, ce_c;
    logic   shift_en;
    logic   slot_free;
    logic   last_bit_of_word;
    logic   last_bit;

    // A word-completing bit may only be taken when the output slot has room;
    // otherwise the chain is frozen for that cycle.
    assign shift_en = (state_q == ST_SHIFT) && (!last_bit_of_word || slot_free);

    scan_unload_ctrl_word_pack #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) u_pack (
        .clk                (clk),
        .clr_n              (clr_n),
        .shift_i            (shift_en),
        .bit_i              (chain_sout),
        .out_ready_i        (out_ready),
        .out_data_o         (out_data),
        .out_valid_o        (out_valid),
        .slot_free_o        (slot_free),
        .last_bit_of_word_o (last_bit_of_word),
        .last_bit_o         (last_bit)
    );

    always_comb begin
        state_d  = state_q;
        recirc_d = recirc_q;
        sen_c    = 1'b0;
        ce_c     = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                ce_c = func_ce;
                if (start) begin
                    recirc_d = recirc;
                    state_d  = cap ? ST_CAPTURE : ST_SHIFT;
                end
            end
            ST_CAPTURE: begin
                ce_c    = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sen_c = 1'b1;
                ce_c  = shift_en;
                if (shift_en && last_bit) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (slot_free) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Chain enables are forced off while reset is asserted, independent of state.
    assign chain_sen = clr_n & sen_c;
    assign chain_ce  = clr_n & ce_c;
    assign chain_sin = (state_q == ST_SHIFT && recirc_q) ? chain_sout : 1'b0;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q  <= ST_IDLE;
            recirc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            recirc_q <= recirc_d;
        end
    end

endmodule

// File: tb/tb_scan_unload_ctrl.sv
module tb_scan_unload_ctrl;

    localparam int unsigned CL = 40;
    localparam int unsigned WW = 32;

    logic          clk = 1'b0;
    logic          clr_n, start, cap, recirc, func_ce, out_ready;
    logic          chain_sen, chain_ce, chain_sin, chain_sout;
    logic [WW-1:0] out_data;
    logic          out_valid, busy, done;

    logic [CL-1:0] chain_q;
    logic [CL-1:0] chain_d;

    int            checks = 0;
    int            errors = 0;
    logic [WW-1:0] exp_q[$];

    always #5 clk = ~clk;

    scan_unload_ctrl #(
        .CHAIN_LEN (CL),
        .WORD_W    (WW)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .cap        (cap),
        .recirc     (recirc),
        .func_ce    (func_ce),
        .chain_sen  (chain_sen),
        .chain_ce   (chain_ce),
        .chain_sin  (chain_sin),
        .chain_sout (chain_sout),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    // ScanReg40 behavioural chain: sin enters the top cell, sout is q[0].
    assign chain_sout = chain_q[0];
    always @(posedge clk) begin
        if (chain_ce) chain_q <= chain_sen ? {chain_sin, chain_q[CL-1:1]} : chain_d;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: accepted words are popped and compared; a held word must
    // match the pending expected entry.
    always @(negedge clk) begin
        if (clr_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_word", out_data, 64'hx);
            end else if (out_ready) begin
                chk("sb_word", out_data, exp_q.pop_front());
            end else begin
                chk("sb_hold", out_data, exp_q[0]);
            end
        end
    end

    task automatic preload(input logic [CL-1:0] v);
        chain_d = v;
        func_ce = 1'b1;
        @(posedge clk); #1;
        func_ce = 1'b0;
    endtask

    task automatic push_words(input logic [CL-1:0] v);
        logic [63:0] tmp;
        tmp = 64'(v);
        exp_q.push_back(tmp[31:0]);
        exp_q.push_back(tmp[63:32]);
    endtask

    // Issues one unload and walks it cycle by cycle (cycle 1 = first cycle
    // after the start edge). Holds out_ready low over [rlo,rhi]; expects
    // chain_ce low during SHIFT over [clo,chi]; tog pokes start/func_ce
    // while busy.
    task automatic run_unload(input logic c, input logic r,
                              input int rlo, input int rhi,
                              input int clo, input int chi,
                              input logic tog, input int exp_done);
        int done_k;
        done_k = -1;
        start = 1'b1; cap = c; recirc = r;
        @(posedge clk); #1;
        start = 1'b0; cap = 1'b0; recirc = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            out_ready = !(k >= rlo && k <= rhi);
            if (tog && k >= 5 && k <= 10) begin
                start   = 1'b1;
                cap     = 1'b1;
                func_ce = k[0];
            end else begin
                start   = 1'b0;
                cap     = 1'b0;
                func_ce = 1'b0;
            end
            @(negedge clk);
            if (k == 1 && c) begin
                chk("cap_sen", chain_sen, 0);
                chk("cap_ce", chain_ce, 1);
            end
            if (k == rlo) chk("w0_valid_at_stall", out_valid, 1);
            if (chain_sen) chk("shift_ce", chain_ce, (k >= clo && k <= chi) ? 0 : 1);
            if (k == 2) chk("busy_mid", busy, 1);
            if (done) begin
                done_k = k;
                break;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("done_cycle", done_k, exp_done);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        clr_n = 1'b0; start = 1'b0; cap = 1'b0; recirc = 1'b0;
        func_ce = 1'b1; out_ready = 1'b1; chain_d = '0; chain_q = '0;

        // Reset: chain enables forced low even with func_ce=1.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sen", chain_sen, 0);
        chk("rst_ce", chain_ce, 0);
        @(posedge clk); #1;
        clr_n = 1'b1; func_ce = 1'b0;

        // 1: plain unload, zeros shifted in.
        preload(40'h12_3456_789A);
        push_words(40'h12_3456_789A);
        run_unload(1'b0, 1'b0, 0, -1, 0, -1, 1'b0, 42);
        @(posedge clk); #1;
        chk("t1_chain", chain_q, 0);

        // 2: recirculating unload restores the chain.
        preload(40'h12_3456_789A);
        push_words(40'h12_3456_789A);
        run_unload(1'b0, 1'b1, 0, -1, 0, -1, 1'b0, 42);
        @(posedge clk); #1;
        chk("t2_chain", chain_q, 40'h12_3456_789A);

        // 3: capture cycle first.
        chain_d = 40'hFF_0000_0001;
        push_words(40'hFF_0000_0001);
        run_unload(1'b1, 1'b0, 0, -1, 0, -1, 1'b0, 43);
        @(posedge clk); #1;

        // 4: back-pressure on word0 stalls the last bit of word1 (cycles 40-42).
        preload(40'h12_3456_789A);
        push_words(40'h12_3456_789A);
        run_unload(1'b0, 1'b0, 33, 42, 40, 42, 1'b0, 45);
        @(posedge clk); #1;

        // 5: reset mid-shift after 20 bits.
        preload(40'hA5_C3F0_0F5A);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        clr_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_sen", chain_sen, 0);
        chk("t5_rst_ce", chain_ce, 0);
        @(posedge clk); #1;
        clr_n = 1'b1;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_done", done, 0);
        chk("t5_chain_partial", chain_q, 40'hA5_C3F0_0F5A >> 20);
        @(posedge clk); #1;
        preload(40'h01_8000_0001);
        push_words(40'h01_8000_0001);
        run_unload(1'b0, 1'b0, 0, -1, 0, -1, 1'b0, 42);
        @(posedge clk); #1;

        // 6: start and func_ce activity while busy is ignored.
        preload(40'hDE_ADBE_EF01);
        push_words(40'hDE_ADBE_EF01);
        run_unload(1'b0, 1'b0, 0, -1, 0, -1, 1'b1, 42);
        @(posedge clk); #1;
        chk("t6_idle", busy, 0);
        func_ce = 1'b1;
        #1;
        chk("t6_ce_follow1", chain_ce, 1);
        func_ce = 1'b0;
        #1;
        chk("t6_ce_follow0", chain_ce, 0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
